// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS main control FSM and
//               the downstream ALU control decoder: state codes, opcodes,
//               ALUOp values, datapath mux selects and the control word.
//               Optional feature macro: MC_ADDI_EN (ADDI instruction support).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Controller states; codes 13..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    // Opcode field (IR[31:26]) values recognised by the controller
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    // ALUOp encodings understood by the ALU control decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_SRCB_BREG    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Moore control word produced purely from the current state
    typedef struct packed {
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_word_t;

    // True for every opcode the controller can execute in this build
    function automatic logic is_legal_opcode(input logic [5:0] op);
        logic legal;
        legal = (op == c_OP_RTYPE) || (op == c_OP_LW)  || (op == c_OP_SW) ||
                (op == c_OP_BEQ)   || (op == c_OP_BNE) || (op == c_OP_J);
`ifdef MC_ADDI_EN
        legal = legal || (op == c_OP_ADDI);
`endif
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_outdec
// Description : Pure combinational state -> control word decoder for the
//               multicycle MIPS main controller. FETCH raises ir_write and
//               pc_write unconditionally; the top gates them with mem_ready.
//               Optional feature macro: MC_ADDI_EN (ADDI states decoded).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_cw
);

    // Decode each state into its datapath control word; unused states stay 0
    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH: begin
                o_cw.mem_read  = 1'b1;
                o_cw.iord      = 1'b0;
                o_cw.alu_src_a = 1'b0;
                o_cw.alu_src_b = c_SRCB_FOUR;
                o_cw.alu_op    = c_ALUOP_ADD;
                o_cw.pc_source = c_PCSRC_ALU;
                o_cw.ir_write  = 1'b1;
                o_cw.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut
                o_cw.alu_src_a = 1'b0;
                o_cw.alu_src_b = c_SRCB_IMM_SH2;
                o_cw.alu_op    = c_ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = c_SRCB_IMM;
                o_cw.alu_op    = c_ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_cw.mem_read = 1'b1;
                o_cw.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.mem_to_reg = 1'b1;
                o_cw.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                o_cw.mem_write = 1'b1;
                o_cw.iord      = 1'b1;
            end
            S_R_EXEC: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = c_SRCB_BREG;
                o_cw.alu_op    = c_ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.reg_dst    = 1'b1;
                o_cw.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                o_cw.alu_src_a     = 1'b1;
                o_cw.alu_src_b     = c_SRCB_BREG;
                o_cw.alu_op        = c_ALUOP_SUB;
                o_cw.pc_write_cond = 1'b1;
                o_cw.pc_source     = c_PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_cw.pc_write  = 1'b1;
                o_cw.pc_source = c_PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = c_SRCB_IMM;
                o_cw.alu_op    = c_ALUOP_ADD;
            end
            S_ADDI_WB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.reg_dst    = 1'b0;
                o_cw.mem_to_reg = 1'b0;
            end
`endif
            default: o_cw = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Multicycle MIPS main control FSM. Sequences fetch, decode,
//               execute, memory and writeback, drives ALUOp and all datapath
//               enables, and handshakes with the unified memory via mem_ready.
//               Optional feature macro: MC_ADDI_EN (ADDI instruction support;
//               when undefined opcode 001000 is reported as illegal).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OPC_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic [1:0]         alu_op,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t     r_state;
    state_t     w_next;
    ctrl_word_t w_cw;
    logic [5:0] w_op;
    logic       w_fetch_gate;

    assign w_op = 6'(opcode);

    // State register; reset returns to IDLE at once so no write can follow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing; memory states wait on mem_ready, others advance
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    c_OP_RTYPE:         w_next = S_R_EXEC;
                    c_OP_LW, c_OP_SW:   w_next = S_MEM_ADDR;
                    c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
                    c_OP_J:             w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    c_OP_ADDI:          w_next = S_ADDI_EXEC;
`endif
                    default:            w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (w_op == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
`endif
            default:     w_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_cw    (w_cw)
    );

    // In FETCH the IR and PC only load on the cycle memory delivers the word
    assign w_fetch_gate = (r_state != S_FETCH) || mem_ready;

    assign alu_op        = w_cw.alu_op;
    assign pc_write      = w_cw.pc_write & w_fetch_gate;
    assign pc_write_cond = w_cw.pc_write_cond;
    assign branch_ne     = (r_state == S_BRANCH) && w_op[0];
    assign iord          = w_cw.iord;
    assign mem_read      = w_cw.mem_read;
    assign mem_write     = w_cw.mem_write;
    assign ir_write      = w_cw.ir_write & w_fetch_gate;
    assign mem_to_reg    = w_cw.mem_to_reg;
    assign reg_dst       = w_cw.reg_dst;
    assign reg_write     = w_cw.reg_write;
    assign alu_src_a     = w_cw.alu_src_a;
    assign alu_src_b     = w_cw.alu_src_b;
    assign pc_source     = w_cw.pc_source;
    assign illegal_op    = (r_state == S_DECODE) && !is_legal_opcode(w_op);
    assign dbg_state     = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_control
// Description : Self-checking bench for mc_main_control. An instruction-level
//               model expands each opcode into its expected per-cycle state and
//               control outputs; directed cases are followed by random ones.
//               Honours MC_ADDI_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       illegal_op;
    logic [3:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    obs_t       q_exp[$];
    logic       q_rdy[$];
    logic [5:0] q_opc[$];

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .dbg_state     (dbg_state)
    );

    function automatic obs_t sample();
        obs_t o;
        o.st = dbg_state;            o.alu_op = alu_op;
        o.pc_write = pc_write;       o.pc_write_cond = pc_write_cond;
        o.branch_ne = branch_ne;     o.iord = iord;
        o.mem_read = mem_read;       o.mem_write = mem_write;
        o.ir_write = ir_write;       o.mem_to_reg = mem_to_reg;
        o.reg_dst = reg_dst;         o.reg_write = reg_write;
        o.alu_src_a = alu_src_a;     o.alu_src_b = alu_src_b;
        o.pc_source = pc_source;     o.illegal = illegal_op;
        return o;
    endfunction

    function automatic bit model_legal(input logic [5:0] op);
        bit ok;
        ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) ||
             (op == 6'd4) || (op == 6'd5)  || (op == 6'd2);
`ifdef MC_ADDI_EN
        ok = ok || (op == 6'd8);
`endif
        return ok;
    endfunction

    task automatic check(input obs_t exp, input string tag);
        obs_t got;
        got = sample();
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h (state got %0d exp %0d)",
                   tag, got, exp, got.st, exp.st);
        end
    endtask

    task automatic push(input obs_t o, input logic rdy, input logic [5:0] opc);
        q_exp.push_back(o);
        q_rdy.push_back(rdy);
        q_opc.push_back(opc);
    endtask

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    // sf = fetch wait cycles, sm = data-memory wait cycles.
    task automatic build_instr(input logic [5:0] opc, input int sf, input int sm);
        obs_t o;
        o = '0; o.st = 4'd1; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        for (int i = 0; i < sf; i++) push(o, 1'b0, opc);
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, 1'b1, opc);
        o = '0; o.st = 4'd2; o.alu_src_b = 2'b11; o.illegal = !model_legal(opc);
        push(o, 1'($urandom_range(0, 1)), opc);
        if (!model_legal(opc)) return;
        case (opc)
            6'd0: begin
                o = '0; o.st = 4'd7; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
                push(o, 1'($urandom_range(0, 1)), opc);
                o = '0; o.st = 4'd8; o.reg_write = 1'b1; o.reg_dst = 1'b1;
                push(o, 1'($urandom_range(0, 1)), opc);
            end
            6'd35, 6'd43: begin
                o = '0; o.st = 4'd3; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(o, 1'($urandom_range(0, 1)), opc);
                o = '0; o.iord = 1'b1;
                if (opc == 6'd35) begin
                    o.st = 4'd4; o.mem_read = 1'b1;
                end else begin
                    o.st = 4'd6; o.mem_write = 1'b1;
                end
                for (int i = 0; i < sm; i++) push(o, 1'b0, opc);
                push(o, 1'b1, opc);
                if (opc == 6'd35) begin
                    o = '0; o.st = 4'd5; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                    push(o, 1'($urandom_range(0, 1)), opc);
                end
            end
            6'd4, 6'd5: begin
                o = '0; o.st = 4'd9; o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                o.pc_write_cond = 1'b1; o.pc_source = 2'b01; o.branch_ne = opc[0];
                push(o, 1'($urandom_range(0, 1)), opc);
            end
            6'd2: begin
                o = '0; o.st = 4'd10; o.pc_write = 1'b1; o.pc_source = 2'b10;
                push(o, 1'($urandom_range(0, 1)), opc);
            end
            default: begin
                // ADDI (only reachable when the feature is enabled)
                o = '0; o.st = 4'd11; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(o, 1'($urandom_range(0, 1)), opc);
                o = '0; o.st = 4'd12; o.reg_write = 1'b1;
                push(o, 1'($urandom_range(0, 1)), opc);
            end
        endcase
    endtask

    // Drive each expected cycle's inputs on the falling edge, check 1ns later.
    // Stops after a cycle whose expected state equals stop_st (0 = run all).
    task automatic run_queue(input string tag, input logic [3:0] stop_st);
        obs_t o;
        int   c;
        c = 0;
        while (q_exp.size() > 0) begin
            o = q_exp.pop_front();
            @(negedge clk);
            mem_ready = q_rdy.pop_front();
            opcode    = q_opc.pop_front();
            #1;
            check(o, $sformatf("%s_c%0d", tag, c));
            c++;
            if (stop_st != 4'd0 && o.st == stop_st) begin
                q_exp.delete(); q_rdy.delete(); q_opc.delete();
            end
        end
    endtask

    task automatic do_instr(input logic [5:0] opc, input int sf, input int sm,
                            input string tag);
        build_instr(opc, sf, sm);
        run_queue(tag, 4'd0);
    endtask

    initial begin
        obs_t       zero;
        logic [5:0] op_list [7];
        logic [5:0] opc;
        zero = '0;
        op_list[0] = 6'd0;  op_list[1] = 6'd35; op_list[2] = 6'd43;
        op_list[3] = 6'd4;  op_list[4] = 6'd5;  op_list[5] = 6'd2;
        op_list[6] = 6'd8;

        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        repeat (2) begin
            @(negedge clk); #1;
            check(zero, "reset_idle");
        end
        @(negedge clk); rst_n = 1'b1; #1;
        check(zero, "idle_after_release");

        // Directed instructions
        do_instr(6'd0,  0, 0, "rtype");
        do_instr(6'd0,  3, 0, "fetch_wait3");
        do_instr(6'd35, 0, 0, "lw");
        do_instr(6'd43, 0, 0, "sw");
        do_instr(6'd35, 2, 3, "lw_waits");
        do_instr(6'd43, 1, 2, "sw_waits");
        do_instr(6'd5,  0, 0, "bne");
        do_instr(6'd4,  0, 0, "beq");
        do_instr(6'd2,  0, 0, "jump");
        do_instr(6'd8,  0, 0, "addi");
        do_instr(6'h3F, 0, 0, "illegal_3f");
        do_instr(6'd0,  0, 0, "after_illegal");

        // Reset asserted mid-lw while waiting in MEM_READ
        build_instr(6'd35, 0, 5);
        run_queue("lw_pre_reset", 4'd4);
        #1 rst_n = 1'b0;
        #1 check(zero, "reset_async_midlw");
        repeat (3) begin
            @(negedge clk); #1;
            check(zero, "reset_hold");
        end
        @(negedge clk); rst_n = 1'b1; #1;
        check(zero, "idle_after_midlw");
        do_instr(6'd35, 0, 0, "lw_after_reset");

        // Random instruction mix with random memory wait states
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 7) opc = 6'($urandom);
            else                           opc = op_list[$urandom_range(0, 6)];
            do_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3),
                     $sformatf("rnd%0d_op%0h", n, opc));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
